// File: rtl/udma_sdio_cmd_seq.sv
// SD command sequencer: programs the uDMA SDIO cfg registers, polls STATUS, then returns the response words.
// Define SDIO_CMD_SEQ_CLKDIV_EN to add req_clk_div_i and a CLK_DIV write whenever the divider changes.
module udma_sdio_cmd_seq #(
    parameter int POLL_GAP      = 4,
    parameter int TIMEOUT_POLLS = 1024
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [5:0]   req_cmd_op_i,
    input  logic [31:0]  req_cmd_arg_i,
    input  logic [2:0]   req_rsp_type_i,
    input  logic [31:0]  req_data_setup_i,
`ifdef SDIO_CMD_SEQ_CLKDIV_EN
    input  logic [7:0]   req_clk_div_i,
`endif
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [127:0] rsp_data_o,
    output logic [15:0]  rsp_status_o,
    output logic         rsp_err_o,
    output logic         rsp_timeout_o,
    output logic         busy_o,
    output logic         cfg_valid_o,
    output logic         cfg_rwn_o,
    output logic [4:0]   cfg_addr_o,
    output logic [31:0]  cfg_data_o,
    input  logic [31:0]  cfg_data_i,
    input  logic         cfg_ready_i
);

    localparam logic [4:0] ADDR_CMD_OP  = 5'h08;
    localparam logic [4:0] ADDR_CMD_ARG = 5'h09;
    localparam logic [4:0] ADDR_SETUP   = 5'h0A;
    localparam logic [4:0] ADDR_START   = 5'h0B;
    localparam logic [4:0] ADDR_RSP0    = 5'h0C;
    localparam logic [4:0] ADDR_CLK_DIV = 5'h10;
    localparam logic [4:0] ADDR_STATUS  = 5'h11;
    localparam int PW = $clog2(TIMEOUT_POLLS + 1);
    localparam int GW = $clog2(POLL_GAP + 2);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_CLKDIV, S_WR_OP, S_WR_ARG, S_WR_SETUP, S_WR_START,
        S_POLL_RD, S_POLL_WAIT, S_CLR_STAT, S_RD_RSP, S_DONE
    } state_t;

    state_t         state_r;
    logic [5:0]     op_r;
    logic [31:0]    arg_r;
    logic [2:0]     type_r;
    logic [31:0]    setup_r;
    logic [PW-1:0]  poll_cnt_r;
    logic [GW-1:0]  gap_cnt_r;
    logic [1:0]     rsp_idx_r;
    logic           cfg_valid_r, cfg_rwn_r;
    logic [4:0]     cfg_addr_r;
    logic [31:0]    cfg_data_r;
    logic           rsp_valid_r, rsp_err_r, rsp_timeout_r;
    logic [127:0]   rsp_data_r;
    logic [15:0]    rsp_status_r;
    logic           req_ready_r, busy_r;
`ifdef SDIO_CMD_SEQ_CLKDIV_EN
    logic [7:0]     div_r, last_div_r;
    logic           div_valid_r;
`endif

    logic           txn_en_s, txn_rwn_s, cfg_done_s;
    logic [4:0]     txn_addr_s;
    logic [31:0]    txn_data_s;
    logic [PW-1:0]  poll_next_s;
    logic [1:0]     last_rsp_s;

    // Decode the cfg transaction owned by the current state and the saturating poll count.
    always_comb begin
        txn_en_s   = 1'b1;
        txn_rwn_s  = 1'b0;
        txn_addr_s = 5'h00;
        txn_data_s = 32'h0000_0000;
        case (state_r)
`ifdef SDIO_CMD_SEQ_CLKDIV_EN
            S_WR_CLKDIV: begin txn_addr_s = ADDR_CLK_DIV; txn_data_s = {23'h0, 1'b1, div_r}; end
`endif
            S_WR_OP:     begin txn_addr_s = ADDR_CMD_OP;  txn_data_s = {18'h0, op_r, 5'h0, type_r}; end
            S_WR_ARG:    begin txn_addr_s = ADDR_CMD_ARG; txn_data_s = arg_r; end
            S_WR_SETUP:  begin txn_addr_s = ADDR_SETUP;   txn_data_s = setup_r; end
            S_WR_START:  begin txn_addr_s = ADDR_START;   txn_data_s = 32'h0000_0001; end
            S_POLL_RD:   begin txn_addr_s = ADDR_STATUS;  txn_rwn_s = 1'b1; end
            S_CLR_STAT:  begin txn_addr_s = ADDR_STATUS;  txn_data_s = 32'h0000_0003; end
            S_RD_RSP:    begin txn_addr_s = ADDR_RSP0 + {3'b000, rsp_idx_r}; txn_rwn_s = 1'b1; end
            default:     txn_en_s = 1'b0;
        endcase
        cfg_done_s  = cfg_valid_r & cfg_ready_i;
        last_rsp_s  = (type_r == 3'd2) ? 2'd3 : 2'd0;
        if (poll_cnt_r == PW'(TIMEOUT_POLLS)) begin
            poll_next_s = poll_cnt_r;
        end else begin
            poll_next_s = poll_cnt_r + PW'(1);
        end
    end

    // Sequencer FSM with registered cfg master and response outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r       <= S_IDLE;
            op_r          <= 6'h00;
            arg_r         <= 32'h0;
            type_r        <= 3'h0;
            setup_r       <= 32'h0;
            poll_cnt_r    <= '0;
            gap_cnt_r     <= '0;
            rsp_idx_r     <= 2'd0;
            cfg_valid_r   <= 1'b0;
            cfg_rwn_r     <= 1'b0;
            cfg_addr_r    <= 5'h00;
            cfg_data_r    <= 32'h0;
            rsp_valid_r   <= 1'b0;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
            rsp_data_r    <= 128'h0;
            rsp_status_r  <= 16'h0;
            req_ready_r   <= 1'b1;
            busy_r        <= 1'b0;
`ifdef SDIO_CMD_SEQ_CLKDIV_EN
            div_r         <= 8'h00;
            last_div_r    <= 8'h00;
            div_valid_r   <= 1'b0;
`endif
        end else begin
            // A new transaction is launched only after the previous one has retired.
            if (txn_en_s && !cfg_valid_r) begin
                cfg_valid_r <= 1'b1;
                cfg_rwn_r   <= txn_rwn_s;
                cfg_addr_r  <= txn_addr_s;
                cfg_data_r  <= txn_data_s;
            end else if (cfg_done_s) begin
                cfg_valid_r <= 1'b0;
            end
            case (state_r)
                S_IDLE: if (req_valid_i) begin
                    op_r          <= req_cmd_op_i;
                    arg_r         <= req_cmd_arg_i;
                    type_r        <= req_rsp_type_i;
                    setup_r       <= req_data_setup_i;
                    poll_cnt_r    <= '0;
                    rsp_idx_r     <= 2'd0;
                    rsp_err_r     <= 1'b0;
                    rsp_timeout_r <= 1'b0;
                    rsp_data_r    <= 128'h0;
                    rsp_status_r  <= 16'h0;
                    req_ready_r   <= 1'b0;
                    busy_r        <= 1'b1;
`ifdef SDIO_CMD_SEQ_CLKDIV_EN
                    div_r         <= req_clk_div_i;
                    state_r       <= (!div_valid_r || req_clk_div_i != last_div_r) ? S_WR_CLKDIV : S_WR_OP;
`else
                    state_r       <= S_WR_OP;
`endif
                end
`ifdef SDIO_CMD_SEQ_CLKDIV_EN
                S_WR_CLKDIV: if (cfg_done_s) begin
                    last_div_r  <= div_r;
                    div_valid_r <= 1'b1;
                    state_r     <= S_WR_OP;
                end
`endif
                S_WR_OP:    if (cfg_done_s) state_r <= S_WR_ARG;
                S_WR_ARG:   if (cfg_done_s) state_r <= S_WR_SETUP;
                S_WR_SETUP: if (cfg_done_s) state_r <= S_WR_START;
                S_WR_START: if (cfg_done_s) state_r <= S_POLL_RD;
                S_POLL_RD: if (cfg_done_s) begin
                    poll_cnt_r <= poll_next_s;
                    if (cfg_data_i[1:0] != 2'b00) begin
                        rsp_status_r <= cfg_data_i[31:16];
                        rsp_err_r    <= cfg_data_i[1];
                        state_r      <= S_CLR_STAT;
                    end else if (poll_next_s == PW'(TIMEOUT_POLLS)) begin
                        rsp_timeout_r <= 1'b1;
                        rsp_valid_r   <= 1'b1;
                        state_r       <= S_DONE;
                    end else if (POLL_GAP == 0) begin
                        state_r <= S_POLL_RD;
                    end else begin
                        gap_cnt_r <= GW'(1);
                        state_r   <= S_POLL_WAIT;
                    end
                end
                S_POLL_WAIT: begin
                    if (gap_cnt_r >= GW'(POLL_GAP)) begin
                        state_r <= S_POLL_RD;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GW'(1);
                    end
                end
                S_CLR_STAT: if (cfg_done_s) begin
                    if (rsp_err_r || type_r == 3'd0) begin
                        rsp_valid_r <= 1'b1;
                        state_r     <= S_DONE;
                    end else begin
                        rsp_idx_r <= 2'd0;
                        state_r   <= S_RD_RSP;
                    end
                end
                S_RD_RSP: if (cfg_done_s) begin
                    rsp_data_r[{rsp_idx_r, 5'b00000} +: 32] <= cfg_data_i;
                    if (rsp_idx_r == last_rsp_s) begin
                        rsp_valid_r <= 1'b1;
                        state_r     <= S_DONE;
                    end else begin
                        rsp_idx_r <= rsp_idx_r + 2'd1;
                    end
                end
                S_DONE: if (rsp_ready_i) begin
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= S_IDLE;
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o   = req_ready_r;
    assign busy_o        = busy_r;
    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_data_o    = rsp_data_r;
    assign rsp_status_o  = rsp_status_r;
    assign rsp_err_o     = rsp_err_r;
    assign rsp_timeout_o = rsp_timeout_r;
    assign cfg_valid_o   = cfg_valid_r;
    assign cfg_rwn_o     = cfg_rwn_r;
    assign cfg_addr_o    = cfg_addr_r;
    assign cfg_data_o    = cfg_data_r;

endmodule

// File: tb/tb_udma_sdio_cmd_seq.sv
// Randomised bench for udma_sdio_cmd_seq with a cfg-slave model and a command-level reference model.
module tb_udma_sdio_cmd_seq;
    localparam int POLL_GAP      = 2;
    localparam int TIMEOUT_POLLS = 4;

    logic         clk_i = 1'b0;
    logic         rstn_i = 1'b1;
    logic         req_valid_i = 1'b0;
    logic         req_ready_o;
    logic [5:0]   req_cmd_op_i = 6'h0;
    logic [31:0]  req_cmd_arg_i = 32'h0;
    logic [2:0]   req_rsp_type_i = 3'h0;
    logic [31:0]  req_data_setup_i = 32'h0;
    logic         rsp_valid_o;
    logic         rsp_ready_i = 1'b0;
    logic [127:0] rsp_data_o;
    logic [15:0]  rsp_status_o;
    logic         rsp_err_o, rsp_timeout_o, busy_o;
    logic         cfg_valid_o, cfg_rwn_o;
    logic [4:0]   cfg_addr_o;
    logic [31:0]  cfg_data_o;
    logic [31:0]  cfg_data_i;
    logic         cfg_ready_i;
`ifdef SDIO_CMD_SEQ_CLKDIV_EN
    logic [7:0]   req_clk_div_i = 8'h0;
    logic [7:0]   cur_div = 8'h0;
    logic [7:0]   m_last_div = 8'h0;
    logic         m_div_valid = 1'b0;
`endif

    udma_sdio_cmd_seq #(.POLL_GAP(POLL_GAP), .TIMEOUT_POLLS(TIMEOUT_POLLS)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_cmd_op_i(req_cmd_op_i), .req_cmd_arg_i(req_cmd_arg_i),
        .req_rsp_type_i(req_rsp_type_i), .req_data_setup_i(req_data_setup_i),
`ifdef SDIO_CMD_SEQ_CLKDIV_EN
        .req_clk_div_i(req_clk_div_i),
`endif
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_status_o(rsp_status_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .busy_o(busy_o), .cfg_valid_o(cfg_valid_o), .cfg_rwn_o(cfg_rwn_o),
        .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o), .cfg_data_i(cfg_data_i),
        .cfg_ready_i(cfg_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic rwn; logic [4:0] addr; logic [31:0] data; int cyc; } txn_t;

    int checks = 0;
    int errors = 0;
    txn_t log_q[$];
    int cyc = 0;
    int status_rd_total = 0, status_base = 0, status_len = 1;
    logic [31:0] status_arr[16];
    logic [31:0] rsp_words[4];
    int stall_used = 0, stall_base = 0, stall_amt = 0;
    logic [4:0] stall_addr = 5'h00;
    int stab_err = 0;
    logic stall_prev = 1'b0, snap_rwn = 1'b0;
    logic [4:0] snap_addr = 5'h0;
    logic [31:0] snap_data = 32'h0;

    // cfg slave model: STATUS returns the programmed sequence, RSPn the programmed words.
    always_comb begin
        int off;
        off = status_rd_total - status_base;
        if (off >= status_len) off = status_len - 1;
        cfg_data_i = 32'h0;
        if (cfg_addr_o == 5'h11) cfg_data_i = status_arr[off];
        else if (cfg_addr_o[4:2] == 3'b011) cfg_data_i = rsp_words[cfg_addr_o[1:0]];
        else cfg_data_i = 32'h0;
    end

    assign cfg_ready_i = !(cfg_valid_o && cfg_addr_o == stall_addr && (stall_used - stall_base) < stall_amt);

    // Bus monitor: logs completed transactions and flags any change during a stall.
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (cfg_valid_o && cfg_ready_i) begin
            log_q.push_back('{cfg_rwn_o, cfg_addr_o, cfg_rwn_o ? cfg_data_i : cfg_data_o, cyc});
            if (cfg_rwn_o && cfg_addr_o == 5'h11) status_rd_total <= status_rd_total + 1;
        end
        if (cfg_valid_o && !cfg_ready_i) stall_used <= stall_used + 1;
        if (stall_prev && (!cfg_valid_o || cfg_addr_o != snap_addr || cfg_data_o != snap_data || cfg_rwn_o != snap_rwn))
            stab_err <= stab_err + 1;
        stall_prev <= cfg_valid_o && !cfg_ready_i;
        snap_addr  <= cfg_addr_o;
        snap_data  <= cfg_data_o;
        snap_rwn   <= cfg_rwn_o;
    end

    task automatic start_req(input logic [5:0] op, input logic [31:0] arg, input logic [2:0] typ,
                             input logic [31:0] setup, input string name, output bit ok);
        int t;
        t = 0;
        @(negedge clk_i);
        while (!req_ready_o && t < 50) begin @(negedge clk_i); t++; end
        checks++;
        ok = req_ready_o;
        if (!req_ready_o) begin
            errors++;
            $display("FAIL %s req_ready: got 0 expected 1", name);
        end else begin
            req_cmd_op_i = op; req_cmd_arg_i = arg; req_rsp_type_i = typ; req_data_setup_i = setup;
`ifdef SDIO_CMD_SEQ_CLKDIV_EN
            req_clk_div_i = cur_div;
`endif
            req_valid_i = 1'b1;
            @(negedge clk_i);
            req_valid_i = 1'b0;
            req_cmd_op_i = 6'($urandom); req_cmd_arg_i = $urandom;
            req_rsp_type_i = 3'($urandom); req_data_setup_i = $urandom;
        end
    endtask

    task automatic run_cmd(input logic [5:0] op, input logic [31:0] arg, input logic [2:0] typ,
                           input logic [31:0] setup, input logic [4:0] saddr, input int samt,
                           input int rsp_delay, input string name);
        txn_t exp_q[$];
        txn_t t;
        logic [127:0] e_data;
        logic [15:0] e_status;
        logic e_err, e_timeout, hit;
        logic [31:0] s;
        int k, nr, n, last_rd, log_base, stab0;
        bit ok;
        e_data = 128'h0; e_status = 16'h0; e_err = 1'b0; e_timeout = 1'b0; hit = 1'b0; s = 32'h0;
`ifdef SDIO_CMD_SEQ_CLKDIV_EN
        if (!m_div_valid || cur_div != m_last_div) exp_q.push_back('{1'b0, 5'h10, {23'h0, 1'b1, cur_div}, 0});
        m_last_div = cur_div; m_div_valid = 1'b1;
`endif
        exp_q.push_back('{1'b0, 5'h08, {18'h0, op, 5'h0, typ}, 0});
        exp_q.push_back('{1'b0, 5'h09, arg, 0});
        exp_q.push_back('{1'b0, 5'h0A, setup, 0});
        exp_q.push_back('{1'b0, 5'h0B, 32'h1, 0});
        k = 0;
        while (k < TIMEOUT_POLLS && !hit) begin
            s = status_arr[(k < status_len) ? k : status_len - 1];
            exp_q.push_back('{1'b1, 5'h11, 32'h0, 0});
            k++;
            hit = (s[1:0] != 2'b00);
        end
        if (hit) begin
            e_status = s[31:16]; e_err = s[1];
            exp_q.push_back('{1'b0, 5'h11, 32'h3, 0});
            nr = (e_err || typ == 3'd0) ? 0 : (typ == 3'd2) ? 4 : 1;
            for (int j = 0; j < nr; j++) begin
                exp_q.push_back('{1'b1, 5'(12 + j), 32'h0, 0});
                e_data[32*j +: 32] = rsp_words[j];
            end
        end else begin
            e_timeout = 1'b1;
        end

        log_base = log_q.size(); status_base = status_rd_total;
        stall_base = stall_used; stall_amt = samt; stall_addr = saddr; stab0 = stab_err;
        start_req(op, arg, typ, setup, name, ok);
        if (!ok) return;
        k = 0;
        while (!rsp_valid_o && k < 3000) begin @(negedge clk_i); k++; end
        checks++;
        if (!rsp_valid_o) begin
            errors++;
            $display("FAIL %s rsp_valid: got 0 expected 1 within 3000 cycles", name);
            return;
        end
        for (int d = 0; d <= rsp_delay; d++) begin
            if (d > 0) @(negedge clk_i);
            checks++;
            if (rsp_data_o !== e_data || rsp_status_o !== e_status || rsp_err_o !== e_err ||
                rsp_timeout_o !== e_timeout || rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL %s result[hold %0d]: got data=%h st=%h err=%b to=%b v=%b rdy=%b busy=%b expected data=%h st=%h err=%b to=%b v=1 rdy=0 busy=1",
                         name, d, rsp_data_o, rsp_status_o, rsp_err_o, rsp_timeout_o, rsp_valid_o, req_ready_o, busy_o,
                         e_data, e_status, e_err, e_timeout);
            end
        end
        n = log_q.size() - log_base;
        checks++;
        if (n !== exp_q.size()) begin
            errors++;
            $display("FAIL %s txn_count: got %0d expected %0d", name, n, exp_q.size());
        end
        last_rd = -1;
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            t = log_q[log_base + i];
            checks++;
            if (t.rwn !== exp_q[i].rwn || t.addr !== exp_q[i].addr || (!t.rwn && t.data !== exp_q[i].data)) begin
                errors++;
                $display("FAIL %s txn[%0d]: got rwn=%b addr=%h data=%h expected rwn=%b addr=%h data=%h",
                         name, i, t.rwn, t.addr, t.data, exp_q[i].rwn, exp_q[i].addr, exp_q[i].data);
            end
            if (t.rwn && t.addr == 5'h11) begin
                if (last_rd >= 0) begin
                    checks++;
                    if (t.cyc - last_rd - 1 < POLL_GAP) begin
                        errors++;
                        $display("FAIL %s poll_gap: got %0d idle cycles expected >= %0d", name, t.cyc - last_rd - 1, POLL_GAP);
                    end
                end
                last_rd = t.cyc;
            end
        end
        checks++;
        if (stab_err !== stab0) begin
            errors++;
            $display("FAIL %s cfg_stable: got %0d changes during stall expected 0", name, stab_err - stab0);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s handshake: got v=%b rdy=%b busy=%b expected v=0 rdy=1 busy=0", name, rsp_valid_o, req_ready_o, busy_o);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({req_ready_o, busy_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, cfg_valid_o, cfg_rwn_o, cfg_addr_o} !== 12'b1000_0000_0000 ||
            rsp_data_o !== 128'h0 || rsp_status_o !== 16'h0 || cfg_data_o !== 32'h0) begin
            errors++;
            $display("FAIL %s reset_outputs: got rdy=%b busy=%b v=%b err=%b to=%b cv=%b rwn=%b addr=%h data=%h rsp=%h st=%h expected rdy=1 and all else 0",
                     name, req_ready_o, busy_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, cfg_valid_o, cfg_rwn_o,
                     cfg_addr_o, cfg_data_o, rsp_data_o, rsp_status_o);
        end
    endtask

    task automatic set_status1(input logic [31:0] v);
        status_len = 1; status_arr[0] = v;
    endtask

    task automatic test_reset();
        #2 rstn_i = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    task automatic test_directed();
        status_len = 3; status_arr[0] = 32'h0; status_arr[1] = 32'h0; status_arr[2] = 32'h1;
        run_cmd(6'd0, 32'h0, 3'd0, 32'h1234_5678, 5'h00, 0, 0, "t1_no_rsp");
        set_status1(32'hABCD_0001);
        rsp_words[0] = 32'h1111_1111; rsp_words[1] = 32'h2222_2222;
        rsp_words[2] = 32'h3333_3333; rsp_words[3] = 32'h4444_4444;
        run_cmd(6'd2, 32'hDEAD_BEEF, 3'd2, 32'h0, 5'h00, 0, 0, "t2_r2");
        set_status1(32'h0005_0002);
        run_cmd(6'd17, 32'h55AA_00FF, 3'd1, 32'h0000_0200, 5'h00, 0, 0, "t3_err");
        set_status1(32'h0);
        run_cmd(6'd5, 32'h1, 3'd1, 32'h0, 5'h00, 0, 0, "t4_timeout");
    endtask

    task automatic test_stall();
        set_status1(32'h0001_0001);
        rsp_words[0] = 32'hCAFE_F00D;
        run_cmd(6'd13, 32'h0BAD_CAFE, 3'd1, 32'h7, 5'h09, 3, 5, "t5_stall");
        checks++;
        if (stall_used - stall_base !== 3) begin
            errors++;
            $display("FAIL t5_stall stall_cycles: got %0d expected 3", stall_used - stall_base);
        end
    endtask

    task automatic test_reset_mid();
        int t, base;
        bit ok, seen;
        set_status1(32'h0);
        base = status_rd_total; status_base = status_rd_total; stall_amt = 0;
        start_req(6'd3, 32'h9, 3'd1, 32'h0, "t6_reset", ok);
        t = 0;
        while (status_rd_total - base < 1 && t < 200) begin @(negedge clk_i); t++; end
        checks++;
        if (status_rd_total - base < 1) begin
            errors++;
            $display("FAIL t6_reset first_poll: got 0 reads expected 1");
        end
        @(negedge clk_i);
        rstn_i = 1'b0;
        #1 check_reset_outputs("t6_reset");
`ifdef SDIO_CMD_SEQ_CLKDIV_EN
        m_div_valid = 1'b0; m_last_div = 8'h0;
`endif
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(negedge clk_i); if (rsp_valid_o || cfg_valid_o || !req_ready_o) seen = 1'b1; end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL t6_reset after_reset: got activity expected idle");
        end
    endtask

    task automatic test_random();
        logic [2:0] typ;
        for (int it = 0; it < 24; it++) begin
            status_len = $urandom_range(1, 6);
            for (int i = 0; i < status_len - 1; i++) status_arr[i] = {16'($urandom), 14'($urandom), 2'b00};
            status_arr[status_len - 1] = {16'($urandom), 14'($urandom),
                                          ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3))};
            for (int j = 0; j < 4; j++) rsp_words[j] = $urandom;
            typ = 3'($urandom_range(0, 7));
`ifdef SDIO_CMD_SEQ_CLKDIV_EN
            cur_div = ($urandom_range(0, 1) == 0) ? 8'd8 : 8'd3;
`endif
            run_cmd(6'($urandom), $urandom, typ, $urandom, 5'($urandom_range(8, 17)),
                    $urandom_range(0, 2), $urandom_range(0, 3), $sformatf("rand%0d", it));
        end
    endtask

`ifdef SDIO_CMD_SEQ_CLKDIV_EN
    task automatic test_clkdiv();
        set_status1(32'h1);
        cur_div = 8'd8; run_cmd(6'd1, 32'h0, 3'd0, 32'h0, 5'h00, 0, 0, "div_a");
        cur_div = 8'd8; run_cmd(6'd1, 32'h0, 3'd0, 32'h0, 5'h00, 0, 0, "div_b");
        cur_div = 8'd3; run_cmd(6'd1, 32'h0, 3'd0, 32'h0, 5'h00, 0, 0, "div_c");
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) status_arr[i] = 32'h0;
        for (int j = 0; j < 4; j++) rsp_words[j] = 32'h0;
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid();
`ifdef SDIO_CMD_SEQ_CLKDIV_EN
        test_clkdiv();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
